cnn_axis_conv3x3: RTL and testbench

//  AXI4-Stream 3x3 convolution engine for 8-bit grayscale frames sent in raster order (row-major, one pixel per beat).

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/cnn_line_buffer.sv | 27 ++
 rtl/cnn_axis_conv3x3.sv | 108 ++++++++++
 tb/tb_cnn_axis_conv3x3.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types, default kernel and output clamp for the CNN streaming datapath.
package cnn_pkg;
  localparam int PIX_W      = 8;
  localparam int CNN_COEF_W = 12;
  localparam int ACC_W      = 24;

  typedef logic        [PIX_W-1:0]      pixel_t;
  typedef logic signed [CNN_COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]      acc_t;
  typedef coef_t [0:8]                  kernel_t;

  // Index 0 (top-left) sits in the MSBs.
  localparam kernel_t DEFAULT_KERNEL = {12'sd1, 12'sd2, 12'sd1,
                                        12'sd2, 12'sd4, 12'sd2,
                                        12'sd1, 12'sd2, 12'sd1};

  function automatic pixel_t saturate_u8(input acc_t v);
    if (v < 0)        return '0;
    else if (v > 255) return 8'hff;
    else              return v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/cnn_line_buffer.sv
// Two-row column-addressed line buffer; returns the pixels one and two rows above.
module cnn_line_buffer
  import cnn_pkg::*;
#(
  parameter int IMG_W = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(IMG_W)-1:0] col,
  input  pixel_t                   din,
  output pixel_t                   above1,
  output pixel_t                   above2
);
  pixel_t row1 [IMG_W];
  pixel_t row2 [IMG_W];

  assign above1 = row1[col];
  assign above2 = row2[col];

  // Each column slot ages by one row per write.
  always_ff @(posedge clk) begin
    if (en) begin
      row2[col] <= row1[col];
      row1[col] <= din;
    end
  end
endmodule

// File: rtl/cnn_axis_conv3x3.sv
// AXI4-Stream 3x3 valid-mode convolution: line buffer, 3x3 window, 2-stage MAC, clamped 8-bit output.
module cnn_axis_conv3x3
  import cnn_pkg::*;
#(
  parameter int                  IMG_W  = 32,
  parameter int                  IMG_H  = 32,
  parameter int                  COEF_W = CNN_COEF_W,
  parameter logic [9*COEF_W-1:0] KERNEL = DEFAULT_KERNEL,
  parameter int                  SHIFT  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast
);
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int STAGES = 2;

  logic              adv, accept, win_ok, at_end;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  pixel_t            above1, above2;
  pixel_t [0:8]      win, win_nx;
  acc_t   [0:8]      prod;
  acc_t   [0:2]      s1_row;
  acc_t              sum;
  logic [STAGES:1]   vld_pipe, last_pipe;

  // The whole pipeline moves together; only output backpressure stalls it.
  assign adv           = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = !rst_i && adv;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign win_ok        = (row >= RW'(2)) && (col >= CW'(2));
  assign at_end        = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));

  cnn_line_buffer #(.IMG_W(IMG_W)) u_lb (
    .clk    (clk_i),
    .en     (accept),
    .col    (col),
    .din    (s_axis_tdata),
    .above1 (above1),
    .above2 (above2)
  );

  always_comb begin
    win_nx = win;
    for (int r = 0; r < 3; r++) begin
      win_nx[3*r]   = win[3*r+1];
      win_nx[3*r+1] = win[3*r+2];
    end
    win_nx[2] = above2;
    win_nx[5] = above1;
    win_nx[8] = s_axis_tdata;
  end

  // Products use the post-shift window so stage 1 lines up with the accepting beat.
  for (genvar i = 0; i < 9; i++) begin : g_tap
    assign prod[i] = acc_t'(signed'({1'b0, win_nx[i]})) *
                     acc_t'(signed'(KERNEL[(8-i)*COEF_W +: COEF_W]));
  end

  assign sum = s1_row[0] + s1_row[1] + s1_row[2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col          <= '0;
      row          <= '0;
      win          <= '0;
      s1_row       <= '0;
      vld_pipe     <= '0;
      last_pipe    <= '0;
      m_axis_tdata <= '0;
    end else begin
      if (accept) begin
        win <= win_nx;
        if (s_axis_tlast || at_end) begin
          col <= '0;
          row <= '0;
        end else if (col == CW'(IMG_W-1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (adv) begin
        vld_pipe[1]  <= accept && win_ok;
        last_pipe[1] <= accept && win_ok && at_end;
        for (int r = 0; r < 3; r++)
          s1_row[r] <= prod[3*r] + prod[3*r+1] + prod[3*r+2];
        vld_pipe[2]  <= vld_pipe[1];
        last_pipe[2] <= last_pipe[1];
        if (vld_pipe[1])
          m_axis_tdata <= saturate_u8(acc_t'(sum >>> SHIFT));
      end
    end
  end

  assign m_axis_tvalid = vld_pipe[STAGES];
  assign m_axis_tlast  = last_pipe[STAGES];
endmodule

// File: tb/tb_cnn_axis_conv3x3.sv
// Directed bench: default, saturating and negative-centre kernels driven by one shared input stream.
module tb_cnn_axis_conv3x3;
  localparam int W = 32;
  localparam int H = 32;
  localparam int NOUT = (W-2)*(H-2);
  localparam logic [107:0] K_SAT = {9{12'h004}};
  localparam logic [107:0] K_NEG = {48'h0, 12'hfff, 48'h0};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, m_tready;
  logic       s_tready, s_tready1, s_tready2;
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2, l0, l1, l2;

  int total = 0;
  int bad   = 0;
  bit bp_en = 0;
  int q0[$], q1[$], q2[$];
  bit ql[$];
  int stall_bad = 0, hold_bad = 0;
  logic hold_pend = 1'b0;
  logic [7:0] hold_d;
  logic hold_l;

  always #5 clk = ~clk;

  cnn_axis_conv3x3 #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(d0), .m_axis_tvalid(v0), .m_axis_tready(m_tready), .m_axis_tlast(l0));

  cnn_axis_conv3x3 #(.IMG_W(W), .IMG_H(H), .KERNEL(K_SAT)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1), .s_axis_tlast(s_tlast),
    .m_axis_tdata(d1), .m_axis_tvalid(v1), .m_axis_tready(m_tready), .m_axis_tlast(l1));

  cnn_axis_conv3x3 #(.IMG_W(W), .IMG_H(H), .KERNEL(K_NEG)) u_neg (
    .clk_i(clk), .rst_i(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2), .s_axis_tlast(s_tlast),
    .m_axis_tdata(d2), .m_axis_tvalid(v2), .m_axis_tready(m_tready), .m_axis_tlast(l2));

  // Capture completed handshakes half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst) begin
      if (v0 && m_tready) begin q0.push_back(int'(d0)); ql.push_back(l0); end
      if (v1 && m_tready) q1.push_back(int'(d1));
      if (v2 && m_tready) q2.push_back(int'(d2));
      if (v0 && !m_tready && s_tready) stall_bad <= stall_bad + 1;
      if (hold_pend && (d0 !== hold_d || l0 !== hold_l || v0 !== 1'b1)) hold_bad <= hold_bad + 1;
      hold_pend <= v0 && !m_tready;
      hold_d    <= d0;
      hold_l    <= l0;
    end else begin
      hold_pend <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_en) m_tready = !m_tready;
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); q2.delete(); ql.delete();
  endtask

  task automatic drive_beat(input logic [7:0] px, input bit last);
    bit acc;
    int g;
    s_tdata = px; s_tvalid = 1'b1; s_tlast = last; g = 0; acc = 0;
    do begin
      @(negedge clk);
      acc = s_tready;
      step();
      g++;
    end while (!acc && g < 64);
    if (!acc) begin
      $display("FAIL input_accept timeout: s_axis_tready=%0b required 1", s_tready);
      $fatal(1);
    end
  endtask

  // mode 0: constant val, 1: impulse at (5,5), 2: ramp pixel=col
  task automatic send_frame(input int mode, input int val, input int n_pix, input bit tl);
    for (int p = 0; p < n_pix; p++) begin
      int r = p / W;
      int c = p % W;
      logic [7:0] px;
      case (mode)
        0:       px = val[7:0];
        1:       px = (r == 5 && c == 5) ? 8'd255 : 8'd0;
        default: px = c[7:0];
      endcase
      drive_beat(px, tl && (p == n_pix-1));
    end
  endtask

  task automatic drain(input int n);
    int g = 0;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    while (q0.size() < n && g < 400) begin step(); g++; end
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
    repeat (3) step();
    total++;
    if (v0 !== 1'b0 || l0 !== 1'b0 || d0 !== 8'd0 || s_tready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%0b last=%0b data=%0d s_ready=%0b required 0/0/0/0", v0, l0, d0, s_tready);
    end
    rst = 1'b0;
    step();
    total++;
    if (s_tready !== 1'b1 || v0 !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: s_ready=%0b valid=%0b required 1/0", s_tready, v0);
    end
  endtask

  task automatic test_constant();
    clear_q();
    send_frame(0, 100, W*H, 1);
    drain(NOUT);
    total++;
    if (q0.size() !== NOUT) begin bad++; $display("FAIL const_count: got %0d required %0d", q0.size(), NOUT); end
    foreach (q0[k]) begin
      total++;
      if (q0[k] !== 100 || ql[k] !== (k == NOUT-1)) begin
        bad++;
        if (bad < 20) $display("FAIL const_data k=%0d: data=%0d last=%0b required 100/%0b", k, q0[k], ql[k], k == NOUT-1);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(0, 20, W*H, 0);
    send_frame(0, 30, W*H, 1);
    drain(2*NOUT);
    total++;
    if (q0.size() !== 2*NOUT) begin bad++; $display("FAIL b2b_count: got %0d required %0d", q0.size(), 2*NOUT); end
    foreach (q0[k]) begin
      int exp_d = (k < NOUT) ? 20 : 30;
      bit exp_l = (k == NOUT-1) || (k == 2*NOUT-1);
      total++;
      if (q0[k] !== exp_d || ql[k] !== exp_l) begin
        bad++;
        if (bad < 20) $display("FAIL b2b_data k=%0d: data=%0d last=%0b required %0d/%0b", k, q0[k], ql[k], exp_d, exp_l);
      end
    end
  endtask

  task automatic test_impulse();
    clear_q();
    send_frame(1, 0, W*H, 1);
    drain(NOUT);
    total++;
    if (q0.size() !== NOUT) begin bad++; $display("FAIL impulse_count: got %0d required %0d", q0.size(), NOUT); end
    foreach (q0[k]) begin
      int dr = (k / (W-2)) + 1 - 5;
      int dc = (k % (W-2)) + 1 - 5;
      int exp_d;
      if (dr < 0) dr = -dr;
      if (dc < 0) dc = -dc;
      if (dr > 1 || dc > 1) exp_d = 0;
      else if (dr + dc == 0) exp_d = 63;
      else if (dr + dc == 1) exp_d = 31;
      else exp_d = 15;
      total++;
      if (q0[k] !== exp_d) begin
        bad++;
        if (bad < 20) $display("FAIL impulse_data k=%0d: got %0d required %0d", k, q0[k], exp_d);
      end
    end
  endtask

  task automatic test_saturation();
    clear_q();
    send_frame(0, 255, W*H, 1);
    drain(NOUT);
    total++;
    if (q1.size() !== NOUT || q2.size() !== NOUT) begin
      bad++; $display("FAIL sat_count: got %0d/%0d required %0d", q1.size(), q2.size(), NOUT);
    end
    foreach (q1[k]) begin
      total++;
      if (q1[k] !== 255 || q0[k] !== 255) begin
        bad++;
        if (bad < 20) $display("FAIL sat_data k=%0d: sat=%0d gauss=%0d required 255/255", k, q1[k], q0[k]);
      end
    end
  endtask

  task automatic test_negative();
    clear_q();
    send_frame(0, 50, W*H, 1);
    drain(NOUT);
    total++;
    if (q2.size() !== NOUT) begin bad++; $display("FAIL neg_count: got %0d required %0d", q2.size(), NOUT); end
    foreach (q2[k]) begin
      total++;
      if (q2[k] !== 0 || q1[k] !== 112 || q0[k] !== 50) begin
        bad++;
        if (bad < 20) $display("FAIL neg_data k=%0d: neg=%0d sat=%0d gauss=%0d required 0/112/50", k, q2[k], q1[k], q0[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    stall_bad = 0; hold_bad = 0;
    bp_en = 1'b1;
    send_frame(2, 0, W*H, 1);
    drain(NOUT);
    bp_en = 1'b0; m_tready = 1'b1;
    step();
    total++;
    if (q0.size() !== NOUT) begin bad++; $display("FAIL bp_count: got %0d required %0d", q0.size(), NOUT); end
    foreach (q0[k]) begin
      int exp_d = (k % (W-2)) + 1;
      total++;
      if (q0[k] !== exp_d || ql[k] !== (k == NOUT-1)) begin
        bad++;
        if (bad < 20) $display("FAIL bp_data k=%0d: data=%0d last=%0b required %0d/%0b", k, q0[k], ql[k], exp_d, k == NOUT-1);
      end
    end
    total++;
    if (stall_bad !== 0) begin bad++; $display("FAIL bp_s_ready: stalled cycles with s_ready high=%0d required 0", stall_bad); end
    total++;
    if (hold_bad !== 0) begin bad++; $display("FAIL bp_hold: unstable stalled outputs=%0d required 0", hold_bad); end
  endtask

  task automatic test_truncated();
    clear_q();
    send_frame(0, 200, 100, 1);
    send_frame(0, 9, W*H, 1);
    drain(32 + NOUT);
    total++;
    if (q0.size() !== 32 + NOUT) begin bad++; $display("FAIL trunc_count: got %0d required %0d", q0.size(), 32 + NOUT); end
    foreach (q0[k]) begin
      int exp_d = (k < 32) ? 200 : 9;
      total++;
      if (q0[k] !== exp_d || ql[k] !== (k == 32 + NOUT - 1)) begin
        bad++;
        if (bad < 20) $display("FAIL trunc_data k=%0d: data=%0d last=%0b required %0d/%0b", k, q0[k], ql[k], exp_d, k == 32 + NOUT - 1);
      end
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(0, 200, 100, 0);
    rst = 1'b1;
    step();
    total++;
    if (s_tready !== 1'b0) begin bad++; $display("FAIL midrst_s_ready: got %0b required 0", s_tready); end
    step();
    total++;
    if (v0 !== 1'b0 || l0 !== 1'b0) begin bad++; $display("FAIL midrst_out: valid=%0b last=%0b required 0/0", v0, l0); end
    s_tvalid = 1'b0;
    rst = 1'b0;
    clear_q();
    send_frame(0, 7, W*H, 1);
    drain(NOUT);
    total++;
    if (q0.size() !== NOUT) begin bad++; $display("FAIL midrst_count: got %0d required %0d", q0.size(), NOUT); end
    foreach (q0[k]) begin
      total++;
      if (q0[k] !== 7 || ql[k] !== (k == NOUT-1)) begin
        bad++;
        if (bad < 20) $display("FAIL midrst_data k=%0d: data=%0d last=%0b required 7/%0b", k, q0[k], ql[k], k == NOUT-1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_back_to_back();
    test_impulse();
    test_saturation();
    test_negative();
    test_backpressure();
    test_truncated();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
